// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 4-bit CPU
// Outputs are decoded from state (and op); only state, divider count, div_err and retired are stored.
module multicycle_ctrl #(
   parameter int DIV_TIMEOUT = 8,
   parameter int RET_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             div_done,
   output logic             pcwrite,
   output logic             irwrite,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             memtoreg,
   output logic             regdst,
   output logic             regwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsrc,
   output logic             div_start,
   output logic             div_err,
   output logic [2:0]       state,
   output logic [RET_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_DIVW   = 3'd5,
      S_BRJ    = 3'd6,
      S_IDLE   = 3'd7
   } state_t;

   localparam logic [7:0] DIV_LIMIT = 8'(DIV_TIMEOUT);

   state_t     cur, nxt;
   logic [7:0] div_cnt;
   logic       div_last;
   logic       div_to;
   logic       retire;

   assign state = cur;

   // div_cnt holds completed DIVW cycles, so the current cycle is div_cnt+1
   assign div_last = (div_cnt + 8'd1) == DIV_LIMIT;
   assign div_to   = (cur == S_DIVW) && !div_done && div_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur     <= S_IDLE;
         div_cnt <= 8'd0;
         div_err <= 1'b0;
         retired <= '0;
      end else begin
         cur <= nxt;
         if (cur == S_DIVW)
            div_cnt <= (nxt == S_DIVW) ? div_cnt + 8'd1 : 8'd0;
         if (div_to)
            div_err <= 1'b1;
         if (retire)
            retired <= retired + RET_W'(1);
      end
   end

   always_comb begin
      nxt       = cur;
      retire    = 1'b0;
      pcwrite   = 1'b0;
      irwrite   = 1'b0;
      iord      = 1'b0;
      memread   = 1'b0;
      memwrite  = 1'b0;
      memtoreg  = 1'b0;
      regdst    = 1'b0;
      regwrite  = 1'b0;
      alusrca   = 1'b0;
      alusrcb   = 2'b00;
      aluop     = 2'b00;
      pcsrc     = 2'b00;
      div_start = 1'b0;
      case (cur)
         S_IDLE: nxt = S_FETCH;
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            if (mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               nxt     = S_DECODE;
            end
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            if (op == 4'h8)
               nxt = S_DIVW;
            else if (op >= 4'hE)
               nxt = S_BRJ;
            else
               nxt = S_EXEC;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            if (op <= 4'd9) begin
               aluop = 2'b10;
            end else begin
               alusrcb = 2'b10;
               aluop   = (op == 4'hD) ? 2'b01 : 2'b00;
            end
            nxt = (op == 4'hA || op == 4'hB) ? S_MEM : S_WB;
         end
         S_MEM: begin
            iord     = 1'b1;
            memread  = (op == 4'hA);
            memwrite = (op == 4'hB);
            if (mem_ready) begin
               if (op == 4'hA) begin
                  nxt = S_WB;
               end else begin
                  nxt    = S_FETCH;
                  retire = 1'b1;
               end
            end
         end
         S_WB: begin
            regwrite = 1'b1;
            regdst   = (op <= 4'd9);
            memtoreg = (op == 4'hA);
            nxt      = S_FETCH;
            retire   = 1'b1;
         end
         S_DIVW: begin
            alusrca   = 1'b1;
            aluop     = 2'b10;
            div_start = (div_cnt == 8'd0);
            // a done arriving on the timeout cycle still writes back
            if (div_done) begin
               nxt = S_WB;
            end else if (div_last) begin
               nxt    = S_FETCH;
               retire = 1'b1;
            end
         end
         S_BRJ: begin
            nxt    = S_FETCH;
            retire = 1'b1;
            if (op == 4'hE) begin
               alusrca = 1'b1;
               aluop   = 2'b01;
               pcwrite = zero;
               pcsrc   = 2'b01;
            end else begin
               pcwrite = 1'b1;
               pcsrc   = 2'b10;
            end
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized instruction bench for multicycle_ctrl
// Per-instruction expectations come from a state-list and CPI model of the sequencer.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rst2 = 1'b0;
   logic [3:0]  op = 4'h0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        div_done = 1'b0;

   logic        pcwrite, irwrite, iord, memread, memwrite, memtoreg, regdst, regwrite;
   logic        alusrca, div_start, div_err;
   logic [1:0]  alusrcb, aluop, pcsrc;
   logic [2:0]  state;
   logic [15:0] retired;

   logic        w_pcwrite, w_irwrite, w_iord, w_memread, w_memwrite, w_memtoreg, w_regdst, w_regwrite;
   logic        w_alusrca, w_div_start, w_div_err;
   logic [1:0]  w_alusrcb, w_aluop, w_pcsrc;
   logic [2:0]  w_state;
   logic [3:0]  w_retired;

   int          total = 0;
   int          bad = 0;
   logic [15:0] m_ret = 16'd0;
   logic        m_err = 1'b0;

   multicycle_ctrl #(.DIV_TIMEOUT(8), .RET_W(16)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready), .div_done(div_done),
      .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord), .memread(memread), .memwrite(memwrite),
      .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .div_start(div_start), .div_err(div_err),
      .state(state), .retired(retired)
   );

   multicycle_ctrl #(.DIV_TIMEOUT(8), .RET_W(4)) dut_wrap (
      .clk(clk), .reset(rst2), .op(4'hB), .zero(1'b0), .mem_ready(1'b1), .div_done(1'b0),
      .pcwrite(w_pcwrite), .irwrite(w_irwrite), .iord(w_iord), .memread(w_memread),
      .memwrite(w_memwrite), .memtoreg(w_memtoreg), .regdst(w_regdst), .regwrite(w_regwrite),
      .alusrca(w_alusrca), .alusrcb(w_alusrcb), .aluop(w_aluop), .pcsrc(w_pcsrc),
      .div_start(w_div_start), .div_err(w_div_err), .state(w_state), .retired(w_retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Starts and ends at a negedge with the DUT in FETCH.
   task automatic run_instr(input logic [3:0] o, input int fw, input int mw, input int dl, input logic z);
      int          q[$];
      int          cf = 0, cm = 0, cd = 0, cyc = 0;
      int          n_ir = 0, n_pc = 0, n_mw = 0, n_mr = 0, n_rw = 0, n_ds = 0;
      logic        left = 1'b0, to, rw;
      logic        rdst = 1'b0, mtr = 1'b0;
      logic [1:0]  last_pcsrc = 2'b00;
      logic [4:0]  dec_ctl = 5'd0, ex_ctl = 5'd0, exp_ex;
      logic [63:0] hist = 64'd0, ehist = 64'd0;
      logic [2:0]  st;
      op = o;
      to = (o == 4'h8) && (dl == 0 || dl > 8);
      rw = !(o == 4'hB || o == 4'hE || o == 4'hF || to);
      repeat (fw + 1) q.push_back(0);
      q.push_back(1);
      if (o == 4'h8) begin
         repeat (to ? 8 : dl) q.push_back(5);
         if (!to) q.push_back(4);
      end else if (o >= 4'hE) begin
         q.push_back(6);
      end else begin
         q.push_back(2);
         if (o == 4'hA || o == 4'hB) repeat (mw + 1) q.push_back(3);
         if (o != 4'hB) q.push_back(4);
      end
      foreach (q[i]) ehist = {ehist[60:0], 3'(q[i])};
      exp_ex = (o <= 4'd9 && o != 4'h8) ? 5'b10010 : (o == 4'hD) ? 5'b11001 :
               (o >= 4'hA && o <= 4'hC) ? 5'b11000 : 5'b00000;

      chk("start_fetch", state, 0);
      while (1) begin
         st = state;
         if (left && st == 3'd0) break;
         if (st != 3'd0) left = 1'b1;
         if (cyc >= 40) begin
            chk("cycle_bound", cyc, q.size());
            break;
         end
         mem_ready = (st == 3'd0) ? (cf == fw) : (st == 3'd3) ? (cm == mw) : 1'($urandom);
         div_done  = (st == 3'd5) ? (cd + 1 == dl) : 1'($urandom);
         zero      = (st == 3'd6) ? z : 1'($urandom);
         #1;
         hist = {hist[60:0], st};
         cyc++;
         n_ir += int'(irwrite);
         n_mr += int'(memread);
         n_mw += int'(memwrite);
         n_ds += int'(div_start);
         if (pcwrite) begin
            n_pc++;
            last_pcsrc = pcsrc;
         end
         if (regwrite) begin
            n_rw++;
            rdst = regdst;
            mtr  = memtoreg;
         end
         if (st == 3'd1) dec_ctl = {alusrca, alusrcb, aluop};
         if (st == 3'd2) ex_ctl = {alusrca, alusrcb, aluop};
         if (st == 3'd0) cf++;
         if (st == 3'd3) cm++;
         if (st == 3'd5) cd++;
         @(negedge clk);
      end

      m_ret = m_ret + 16'd1;
      m_err = m_err | to;
      chk($sformatf("cycles_op%0h", o), cyc, q.size());
      chk($sformatf("states_op%0h", o), hist, ehist);
      chk("irwrite_cnt", n_ir, 1);
      chk("memread_cnt", n_mr, fw + 1 + ((o == 4'hA) ? mw + 1 : 0));
      chk("memwrite_cnt", n_mw, (o == 4'hB) ? mw + 1 : 0);
      chk("pcwrite_cnt", n_pc, 1 + ((o == 4'hF || (o == 4'hE && z)) ? 1 : 0));
      chk("pcsrc_last", last_pcsrc, (o == 4'hF) ? 2'b10 : (o == 4'hE && z) ? 2'b01 : 2'b00);
      chk("regwrite_cnt", n_rw, rw ? 1 : 0);
      chk("regdst", rdst, rw && o <= 4'd9);
      chk("memtoreg", mtr, rw && o == 4'hA);
      chk("div_start_cnt", n_ds, (o == 4'h8) ? 1 : 0);
      chk("decode_alu", dec_ctl, 5'b01100);
      chk("exec_alu", ex_ctl, exp_ex);
      chk("retired", retired, m_ret);
      chk("div_err", div_err, m_err);
   endtask

   initial begin
      int steps;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", state, 7);
      chk("rst_retired", retired, 0);
      chk("rst_div_err", div_err, 0);
      chk("rst_strobes", {memread, memwrite, regwrite, pcwrite, irwrite, div_start}, 0);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("idle_after_rst", state, 7);
      @(posedge clk);
      #1 chk("fetch_after_idle", state, 0);
      @(negedge clk);

      run_instr(4'h3, 0, 0, 0, 1'b0);
      run_instr(4'hA, 2, 2, 0, 1'b0);
      run_instr(4'hE, 0, 0, 0, 1'b1);
      run_instr(4'hE, 0, 0, 0, 1'b0);
      run_instr(4'hF, 0, 0, 0, 1'b0);
      run_instr(4'h8, 0, 0, 3, 1'b0);
      run_instr(4'h8, 0, 0, 8, 1'b0);
      run_instr(4'hB, 0, 0, 0, 1'b0);
      run_instr(4'h8, 0, 0, 0, 1'b0);
      for (int i = 0; i < 40; i++)
         run_instr(4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 10)), 1'($urandom));

      // reset asserted mid-STORE while the write is still pending
      op = 4'hB;
      steps = 0;
      while (state != 3'd3 && steps < 10) begin
         mem_ready = 1'b1;
         @(negedge clk);
         steps++;
      end
      chk("reached_mem", state, 3);
      mem_ready = 1'b0;
      #1 chk("memwrite_pending", memwrite, 1);
      #1 reset = 1'b0;
      #1;
      chk("memwrite_in_rst", memwrite, 0);
      chk("state_in_rst", state, 7);
      chk("retired_in_rst", retired, 0);
      chk("div_err_in_rst", div_err, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1 chk("idle_after_rst2", state, 7);
      @(posedge clk);
      #1;
      chk("fetch_after_rst2", state, 0);
      chk("retired_after_rst2", retired, 0);
      @(negedge clk);
      m_ret = 16'd0;
      m_err = 1'b0;
      run_instr(4'hB, 1, 1, 0, 1'b0);

      rst2 = 1'b1;
      repeat (61) @(posedge clk);
      #1 chk("wrap_at_15", w_retired, 15);
      repeat (4) @(posedge clk);
      #1 chk("wrap_to_0", w_retired, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
